dma_read_sched: RTL and testbench
=================================

# dma_read_sched

Multi-channel job sequencer and arbiter in front of `dma_read_ctrl`. Each requester channel (e.g. weights, activations) posts a strided read job: base address, stride, transfer count and per-transfer length. The block splits every job into single transfers and shares the one DMA read engine between channels in round-robin order, one transfer per grant. It drives the engine's start address, length and valid inputs, and consumes its idle and IRQ outputs.

## Interface
- `NUM_CH`, 2: number of requester channels (2..8).
- `CNT_W`, 16: width of the per-job transfer count.
- `TIMEOUT_CYC`, 4096: watchdog limit in WAIT, counted in cycles (used only with the macro).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-low reset.
- `ch_start` in NUM_CH: per-channel job start pulse.
- `ch_base_addr` in NUM_CH*32: per-channel first start address.
- `ch_stride` in NUM_CH*32: per-channel address increment between transfers.
- `ch_count` in NUM_CH*CNT_W: per-channel number of transfers.
- `ch_length` in NUM_CH*26: per-channel length of each transfer.
- `ch_busy` out NUM_CH: job accepted and not finished.
- `ch_done` out NUM_CH: one-cycle pulse when a job completes or aborts.
- `ch_err` out NUM_CH: one-cycle pulse, coincident with `ch_done`, on watchdog abort.
- `dma_read_valid` out 1: one-cycle start strobe to `dma_read_ctrl`.
- `dma_sa_config` out 32: transfer start address.
- `dma_length_config` out 26: transfer length.
- `dma_idle` in 1: engine ready for a new transfer.
- `DMA_IRQ` in 1: engine completion pulse.

## Operation
- **Job acceptance**
  - `ch_start[i]` is sampled only while `ch_busy[i]`=0. A start while busy is ignored.
  - On acceptance, base, stride, count and length are latched, and the remaining count is set to `ch_count`.
  - `ch_count`=0: no transfer is issued, `ch_busy` stays 0, and `ch_done[i]` pulses the next cycle.
- **Pending**: a channel is pending when `ch_busy`=1 and no transfer of that channel is currently in flight.
- **FSM states**: IDLE, ISSUE, WAIT.
  - IDLE: when `dma_idle`=1 and any channel is pending, grant the first pending channel at or after the round-robin pointer. Load `dma_sa_config` with that channel's current address and `dma_length_config` with its length, then go to ISSUE. If `dma_idle`=0, stay in IDLE.
  - ISSUE: `dma_read_valid`=1 for exactly this cycle, then go to WAIT.
  - WAIT: on `DMA_IRQ`=1:
    - add stride to the granted channel's current address and decrement its remaining count;
    - if the remaining count reaches 0, clear `ch_busy` and pulse `ch_done`;
    - set the pointer to granted+1 (mod NUM_CH) and go to IDLE.
- `DMA_IRQ` outside WAIT is ignored.
- **Address arithmetic**: 32-bit unsigned, wrapping modulo 2^32. Stride is unsigned.
- **Output stability**: `dma_sa_config` and `dma_length_config` change only on the IDLE→ISSUE transition. They hold their values through WAIT and the following IDLE.
- **Reset**: an active `RST` at any state (including mid-WAIT) abandons all jobs. No `ch_done` is generated for abandoned jobs.

## Timing
- **Reset values**: all outputs 0, FSM in IDLE, pointer 0, all job registers cleared.
- `ch_start` at cycle t → `ch_busy` high at t+1.
  - With `dma_idle`=1, the FSM enters ISSUE at t+2 and `dma_read_valid` is high in cycle t+2.
- `DMA_IRQ` at cycle u (in WAIT):
  - `ch_done` (last transfer) is high in u+1;
  - the next `dma_read_valid` is high in u+2 at the earliest.
- A channel whose `ch_done` is high in u+1 may be restarted by `ch_start` in u+1, because `ch_busy` is already 0.
- **Throughput**: at most one transfer outstanding; minimum 3 cycles from one `dma_read_valid` to the next, plus engine latency.
- **Simultaneous starts**: multiple channels may start in the same cycle; the grant follows the pointer.

## Configuration
- `DMA_SCHED_TIMEOUT_EN` defined:
  - a cycle counter runs in WAIT, cleared on entry to WAIT;
  - if `TIMEOUT_CYC` cycles pass without `DMA_IRQ`, the granted job aborts: `ch_err` and `ch_done` pulse, `ch_busy` clears, the pointer advances and the FSM returns to IDLE.
- Not defined: WAIT lasts until `DMA_IRQ` indefinitely, `ch_err` is constant 0, and `TIMEOUT_CYC` is unused.

## Test plan
- **Single job**: ch0 base 0x0, stride 0x20, count 4, length 0x40, engine model responding.
  - Expect four `dma_read_valid` pulses with `dma_sa_config` 0x0, 0x20, 0x40, 0x60 and length 0x40.
  - Expect `ch_done[0]` one cycle after the 4th IRQ.
- **Round-robin**: ch0 and ch1 started in the same cycle, each with count 2.
  - Expect grants in order ch0, ch1, ch0, ch1.
  - Expect `ch_done[0]` before `ch_done[1]`.
- **Edge cases**:
  - count 0 → `ch_done` at t+1, no `dma_read_valid`, `ch_busy` stays 0;
  - `ch_start` while busy → job unchanged;
  - `dma_idle`=0 → no issue until `dma_idle` rises.
- **Address wrap**: base 0xFFFF_FFE0, stride 0x20, count 2 → start addresses 0xFFFF_FFE0, then 0x0000_0000.
- **Reset mid-WAIT**: `RST`=0 for one cycle → next cycle all outputs 0, no `ch_done`, and a fresh job runs normally afterward.
- **Watchdog**: with `DMA_SCHED_TIMEOUT_EN` and `TIMEOUT_CYC`=16, withhold IRQ.
  - Expect `ch_err` and `ch_done` pulsed 16 cycles after entry to WAIT.
  - The other pending channel is then granted.

Source files
------------

// File: rtl/dma_read_sched_if.sv
// ============================================================================
// Module   : dma_read_sched_if
// Brief    : Channel-side and engine-side signal bundle for dma_read_sched.
//            slave  = scheduler view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_read_sched_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  // Requester channels
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH*32-1:0]    ch_base_addr;
  logic [NUM_CH*32-1:0]    ch_stride;
  logic [NUM_CH*CNT_W-1:0] ch_count;
  logic [NUM_CH*26-1:0]    ch_length;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_err;
  // DMA read engine
  logic                    dma_read_valid;
  logic [31:0]             dma_sa_config;
  logic [25:0]             dma_length_config;
  logic                    dma_idle;
  logic                    DMA_IRQ;

  modport slave (
    input  ch_start, ch_base_addr, ch_stride, ch_count, ch_length,
    input  dma_idle, DMA_IRQ,
    output ch_busy, ch_done, ch_err,
    output dma_read_valid, dma_sa_config, dma_length_config
  );

  modport master (
    output ch_start, ch_base_addr, ch_stride, ch_count, ch_length,
    output dma_idle, DMA_IRQ,
    input  ch_busy, ch_done, ch_err,
    input  dma_read_valid, dma_sa_config, dma_length_config
  );
endinterface

`default_nettype wire

// File: rtl/dma_read_sched.sv
// ============================================================================
// Module   : dma_read_sched
// Brief    : Multi-channel strided read-job sequencer. Splits each job into
//            single transfers and round-robins the one DMA read engine
//            between channels, one transfer per grant.
//            Optional macro DMA_SCHED_TIMEOUT_EN adds a WAIT watchdog that
//            aborts the granted job after TIMEOUT_CYC cycles without IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_read_sched #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           CLK,
  input  logic           RST,
  dma_read_sched_if.slave bus
);

  localparam int c_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q;
  logic [c_IDX_W-1:0]   ptr_q;
  logic [c_IDX_W-1:0]   gnt_q;
  logic [NUM_CH-1:0]    busy_q;
  logic [NUM_CH-1:0]    done_q;
  logic                 valid_q;
  logic [31:0]          sa_q;
  logic [25:0]          len_out_q;

  // Per-channel job context
  logic [31:0]          addr_q   [NUM_CH];
  logic [31:0]          stride_q [NUM_CH];
  logic [25:0]          len_q    [NUM_CH];
  logic [CNT_W-1:0]     rem_q    [NUM_CH];

  logic [c_IDX_W-1:0]   gnt_d;
  logic                 gnt_vld_d;
  logic [c_IDX_W-1:0]   ptr_inc_d;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int                c_WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);
  logic [c_WD_W-1:0]    wdog_q;
  logic [NUM_CH-1:0]    err_q;
  assign bus.ch_err = err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYC;
  assign bus.ch_err       = '0;
`endif

  assign bus.ch_busy           = busy_q;
  assign bus.ch_done           = done_q;
  assign bus.dma_read_valid    = valid_q;
  assign bus.dma_sa_config     = sa_q;
  assign bus.dma_length_config = len_out_q;

  // Pointer follows the last granted channel, wrapping for any NUM_CH.
  assign ptr_inc_d = (gnt_q == c_IDX_W'(NUM_CH - 1)) ? '0 : gnt_q + c_IDX_W'(1);

  // Round-robin pick: lowest busy channel at/after the pointer, else lowest
  // busy channel below it. Arbitration only runs in IDLE, where nothing is
  // in flight, so busy alone means pending.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (busy_q[i] && (i < int'(ptr_q))) begin
        gnt_vld_d = 1'b1;
        gnt_d     = c_IDX_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (busy_q[i] && (i >= int'(ptr_q))) begin
        gnt_vld_d = 1'b1;
        gnt_d     = c_IDX_W'(i);
      end
    end
  end

  // Job acceptance, transfer sequencing FSM and completion bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      valid_q   <= 1'b0;
      sa_q      <= '0;
      len_out_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_q[i]   <= '0;
        stride_q[i] <= '0;
        len_q[i]    <= '0;
        rem_q[i]    <= '0;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      wdog_q <= '0;
      err_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      err_q   <= '0;
`endif
      // A start is only honoured on an idle channel; a zero-count job
      // completes immediately without ever becoming busy.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_start[i] && !busy_q[i]) begin
          addr_q[i]   <= bus.ch_base_addr[i*32 +: 32];
          stride_q[i] <= bus.ch_stride[i*32 +: 32];
          len_q[i]    <= bus.ch_length[i*26 +: 26];
          rem_q[i]    <= bus.ch_count[i*CNT_W +: CNT_W];
          if (bus.ch_count[i*CNT_W +: CNT_W] == '0) begin
            done_q[i] <= 1'b1;
          end else begin
            busy_q[i] <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.dma_idle && gnt_vld_d) begin
            gnt_q     <= gnt_d;
            sa_q      <= addr_q[gnt_d];
            len_out_q <= len_q[gnt_d];
            valid_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.DMA_IRQ) begin
            addr_q[gnt_q] <= addr_q[gnt_q] + stride_q[gnt_q];
            rem_q[gnt_q]  <= rem_q[gnt_q] - CNT_W'(1);
            if (rem_q[gnt_q] == CNT_W'(1)) begin
              busy_q[gnt_q] <= 1'b0;
              done_q[gnt_q] <= 1'b1;
            end
            ptr_q   <= ptr_inc_d;
            state_q <= S_IDLE;
          end
`ifdef DMA_SCHED_TIMEOUT_EN
          else if (wdog_q == c_WD_LAST) begin
            busy_q[gnt_q] <= 1'b0;
            done_q[gnt_q] <= 1'b1;
            err_q[gnt_q]  <= 1'b1;
            ptr_q         <= ptr_inc_d;
            state_q       <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + c_WD_W'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_read_sched.sv
// ============================================================================
// Module   : tb_dma_read_sched
// Brief    : Self-checking bench for dma_read_sched. A scoreboard queue holds
//            expected (address, length) pairs per issued transfer; a small
//            engine model answers each strobe with an IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_read_sched;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 16;
  localparam int TO_CYC  = 16;
  localparam int IRQ_LAT = 3;

  typedef struct {
    logic [31:0] addr;
    logic [25:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   nval = 0;
  int   irq_cyc = -1;
  int   last_valid_cyc = -1;
  logic irq_en = 1'b0;
  logic prev_valid = 1'b0;
  int   countdown = 0;
  exp_t exp_q[$];

  dma_read_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  dma_read_sched #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int ch, input logic [31:0] base, input logic [31:0] stride,
                         input logic [15:0] cnt, input logic [25:0] len);
    bus.ch_base_addr[ch*32 +: 32] = base;
    bus.ch_stride[ch*32 +: 32]    = stride;
    bus.ch_count[ch*CNT_W +: CNT_W] = cnt;
    bus.ch_length[ch*26 +: 26]    = len;
    bus.ch_start[ch]              = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [25:0] len);
    exp_t e;
    e.addr = addr;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int ch, input int max_cyc, output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < max_cyc; k++) begin
      if (bus.ch_done[ch]) begin
        at_cyc = cyc;
        break;
      end
      step();
    end
    chk(tag, 64'(at_cyc >= 0), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ch_start = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Engine model plus scoreboard monitor.
  initial begin : engine_mon
    bus.DMA_IRQ = 1'b0;
    forever begin
      step();
      bus.DMA_IRQ = 1'b0;
      if (!rst_n) begin
        countdown = 0;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.DMA_IRQ = 1'b1;
          irq_cyc     = cyc;
        end
      end
      if (bus.dma_read_valid) begin
        nval++;
        last_valid_cyc = cyc;
        chk("valid_single_cycle", 64'(prev_valid), 64'd0);
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dma_sa_config", 64'(bus.dma_sa_config), 64'(e.addr));
          chk("dma_length_config", 64'(bus.dma_length_config), 64'(e.len));
        end
        if (irq_en) countdown = IRQ_LAT;
      end
      prev_valid = bus.dma_read_valid;
    end
  end

  initial begin : bound
    #400000;
    $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
    $fatal(1, "simulation bound expired");
  end

  initial begin : main
    int at, d0, d1, nv0, done_any;
    rst_n            = 1'b0;
    bus.ch_start     = '0;
    bus.ch_base_addr = '0;
    bus.ch_stride    = '0;
    bus.ch_count     = '0;
    bus.ch_length    = '0;
    bus.dma_idle     = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_busy", 64'(bus.ch_busy), 64'd0);
    chk("rst_done", 64'(bus.ch_done), 64'd0);
    chk("rst_err", 64'(bus.ch_err), 64'd0);
    chk("rst_valid", 64'(bus.dma_read_valid), 64'd0);
    chk("rst_sa", 64'(bus.dma_sa_config), 64'd0);
    chk("rst_len", 64'(bus.dma_length_config), 64'd0);
    rst_n = 1'b1;
    step();

    // Single job: four strided transfers on ch0
    irq_en = 1'b1;
    nv0 = nval;
    set_job(0, 32'h0, 32'h20, 16'd4, 26'h40);
    for (int k = 0; k < 4; k++) push_exp(32'h20 * k, 26'h40);
    step();
    bus.ch_start = '0;
    chk("single_busy_t1", 64'(bus.ch_busy[0]), 64'd1);
    chk("single_valid_t1", 64'(bus.dma_read_valid), 64'd0);
    step();
    chk("single_valid_t2", 64'(bus.dma_read_valid), 64'd1);
    wait_done("single_done_seen", 0, 200, at);
    chk("single_done_after_irq", 64'(at), 64'(irq_cyc + 1));
    chk("single_busy_cleared", 64'(bus.ch_busy[0]), 64'd0);
    chk("single_sb_drained", 64'(exp_q.size()), 64'd0);
    chk("single_valid_count", 64'(nval - nv0), 64'd4);

    // Round-robin: simultaneous starts from pointer 0
    do_reset();
    nv0 = nval;
    set_job(0, 32'h1000, 32'h10, 16'd2, 26'h8);
    set_job(1, 32'h2000, 32'h100, 16'd2, 26'h10);
    push_exp(32'h1000, 26'h8);
    push_exp(32'h2000, 26'h10);
    push_exp(32'h1010, 26'h8);
    push_exp(32'h2100, 26'h10);
    step();
    bus.ch_start = '0;
    d0 = -1;
    d1 = -1;
    for (int k = 0; k < 300; k++) begin
      if (bus.ch_done[0] && d0 < 0) d0 = cyc;
      if (bus.ch_done[1] && d1 < 0) d1 = cyc;
      if (d0 >= 0 && d1 >= 0) break;
      step();
    end
    chk("rr_done0_seen", 64'(d0 >= 0), 64'd1);
    chk("rr_done1_seen", 64'(d1 >= 0), 64'd1);
    chk("rr_done0_first", 64'(d0 < d1), 64'd1);
    chk("rr_sb_drained", 64'(exp_q.size()), 64'd0);
    chk("rr_valid_count", 64'(nval - nv0), 64'd4);

    // Zero-count job: immediate done, never busy, nothing issued
    nv0 = nval;
    set_job(0, 32'h123, 32'h10, 16'd0, 26'h5);
    step();
    bus.ch_start = '0;
    chk("cnt0_done_t1", 64'(bus.ch_done[0]), 64'd1);
    chk("cnt0_busy_t1", 64'(bus.ch_busy[0]), 64'd0);
    step();
    chk("cnt0_done_pulse", 64'(bus.ch_done[0]), 64'd0);
    repeat (5) step();
    chk("cnt0_no_issue", 64'(nval - nv0), 64'd0);

    // Engine not idle, plus a start while busy that must be ignored
    bus.dma_idle = 1'b0;
    nv0 = nval;
    set_job(1, 32'h3000, 32'h4, 16'd1, 26'h20);
    push_exp(32'h3000, 26'h20);
    step();
    bus.ch_start = '0;
    chk("busy_start_busy", 64'(bus.ch_busy[1]), 64'd1);
    set_job(1, 32'h9999_0000, 32'h8, 16'd5, 26'h7);
    step();
    bus.ch_start = '0;
    repeat (10) step();
    chk("idle_low_no_issue", 64'(nval - nv0), 64'd0);
    chk("idle_low_still_busy", 64'(bus.ch_busy[1]), 64'd1);
    bus.dma_idle = 1'b1;
    wait_done("busy_start_done_seen", 1, 200, at);
    chk("busy_start_one_xfer", 64'(nval - nv0), 64'd1);
    chk("busy_start_sb_drained", 64'(exp_q.size()), 64'd0);

    // 32-bit address wrap
    set_job(0, 32'hFFFF_FFE0, 32'h20, 16'd2, 26'h4);
    push_exp(32'hFFFF_FFE0, 26'h4);
    push_exp(32'h0000_0000, 26'h4);
    step();
    bus.ch_start = '0;
    wait_done("wrap_done_seen", 0, 200, at);
    chk("wrap_sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for the engine
    irq_en = 1'b0;
    set_job(1, 32'h5000, 32'h10, 16'd3, 26'h10);
    push_exp(32'h5000, 26'h10);
    step();
    bus.ch_start = '0;
    repeat (6) step();
    chk("midwait_issued", 64'(exp_q.size()), 64'd0);
    nv0 = nval;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midwait_busy", 64'(bus.ch_busy), 64'd0);
    chk("midwait_done", 64'(bus.ch_done), 64'd0);
    chk("midwait_valid", 64'(bus.dma_read_valid), 64'd0);
    chk("midwait_sa", 64'(bus.dma_sa_config), 64'd0);
    chk("midwait_len", 64'(bus.dma_length_config), 64'd0);
    chk("midwait_err", 64'(bus.ch_err), 64'd0);
    done_any = 0;
    repeat (10) begin
      step();
      if (bus.ch_done != '0) done_any = 1;
    end
    chk("midwait_no_done", 64'(done_any), 64'd0);
    chk("midwait_no_reissue", 64'(nval - nv0), 64'd0);
    irq_en = 1'b1;
    set_job(0, 32'h6000, 32'h8, 16'd2, 26'h30);
    push_exp(32'h6000, 26'h30);
    push_exp(32'h6008, 26'h30);
    step();
    bus.ch_start = '0;
    step();
    chk("fresh_valid_t2", 64'(bus.dma_read_valid), 64'd1);
    wait_done("fresh_done_seen", 0, 200, at);
    chk("fresh_sb_drained", 64'(exp_q.size()), 64'd0);

`ifdef DMA_SCHED_TIMEOUT_EN
    // Watchdog abort, then the other pending channel proceeds
    do_reset();
    irq_en = 1'b0;
    set_job(0, 32'h7000, 32'h10, 16'd1, 26'h10);
    set_job(1, 32'h8000, 32'h10, 16'd1, 26'h10);
    push_exp(32'h7000, 26'h10);
    push_exp(32'h8000, 26'h10);
    step();
    bus.ch_start = '0;
    wait_done("wd_done0_seen", 0, 100, at);
    chk("wd_err0", 64'(bus.ch_err[0]), 64'd1);
    chk("wd_latency", 64'(at), 64'(last_valid_cyc + 1 + TO_CYC));
    chk("wd_busy0_cleared", 64'(bus.ch_busy[0]), 64'd0);
    irq_en = 1'b1;
    wait_done("wd_done1_seen", 1, 100, at);
    chk("wd_err1", 64'(bus.ch_err[1]), 64'd0);
    chk("wd_sb_drained", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
